// File: rtl/tc_program_pkg.sv
// Shared types and constants for the program-memory byte-stream writer.
// Optional feature macro: TC_PROGRAM_WRITER_CHECKSUM_EN adds the CSUM state.
package tc_program_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CSUM_W = 8;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLen  = 3'd1,
        StData = 3'd2,
`ifdef TC_PROGRAM_WRITER_CHECKSUM_EN
        StCsum = 3'd3,
`endif
        StDone = 3'd4
    } state_e;

    // A length byte of zero, or one larger than the memory, means "fill the whole memory".
    function automatic logic [8:0] clamp_len(input logic [7:0] len, input logic [8:0] mem_len);
        if (len == 8'd0 || {1'b0, len} > mem_len) begin
            return mem_len;
        end
        return {1'b0, len};
    endfunction

endpackage

// File: rtl/tc_checksum8.sv
// 8-bit modulo-256 running sum with synchronous clear and add enable.
// Instantiated only when TC_PROGRAM_WRITER_CHECKSUM_EN is defined.
module tc_checksum8
    import tc_program_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              add_en,
    input  logic [CSUM_W-1:0] add_data,
    output logic [CSUM_W-1:0] sum
);

    logic [CSUM_W-1:0] sum_q;

    // Accumulate; clear has priority so a new session starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if (clear) begin
            sum_q <= '0;
        end else if (add_en) begin
            sum_q <= sum_q + add_data;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/tc_program_writer8.sv
// Byte-stream program loader: length byte, N data bytes written to program memory
// from a captured base address (modulo MEM_BYTES), then a one-cycle done pulse.
// Define TC_PROGRAM_WRITER_CHECKSUM_EN to add a trailing checksum byte and error flag.
module tc_program_writer8
    import tc_program_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [8:0]        MEM_LEN   = 9'(MEM_BYTES);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(MEM_BYTES - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [8:0]        cnt_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              xfer;
    logic              sess_start;

    assign xfer       = in_valid && in_ready;
    assign sess_start = (state_q == StIdle) && start;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StLen;
            StLen:  if (xfer) state_d = StData;
            StData: begin
                if (xfer && cnt_q == 9'd1) begin
`ifdef TC_PROGRAM_WRITER_CHECKSUM_EN
                    state_d = StCsum;
`else
                    state_d = StDone;
`endif
                end
            end
`ifdef TC_PROGRAM_WRITER_CHECKSUM_EN
            StCsum: if (xfer) state_d = StDone;
`endif
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        in_ready = 1'b0;
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
        unique case (state_q)
            StLen, StData: in_ready = 1'b1;
`ifdef TC_PROGRAM_WRITER_CHECKSUM_EN
            StCsum:        in_ready = 1'b1;
`endif
            default:       in_ready = 1'b0;
        endcase
    end

    // Address/count tracking and the registered (one-cycle-late) write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (sess_start) begin
                addr_q <= base_addr & ADDR_MASK;
                cnt_q  <= '0;
            end
            if (state_q == StLen && xfer) begin
                cnt_q <= clamp_len(in_data, MEM_LEN);
            end
            if (state_q == StData && xfer) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= addr_q;
                wr_data_q <= in_data;
                addr_q    <= (addr_q + 8'd1) & ADDR_MASK;
                cnt_q     <= cnt_q - 9'd1;
            end
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

`ifdef TC_PROGRAM_WRITER_CHECKSUM_EN
    logic [CSUM_W-1:0] sum;
    logic [CSUM_W-1:0] csum_total;
    logic              sum_add;
    logic              error_q;

    // Length byte and data bytes both feed the sum; the checksum byte itself does not.
    assign sum_add    = xfer && (state_q == StLen || state_q == StData);
    assign csum_total = sum + in_data;

    tc_checksum8 u_checksum (
        .clk      (clk),
        .rst      (rst),
        .clear    (sess_start),
        .add_en   (sum_add),
        .add_data (in_data),
        .sum      (sum)
    );

    // Sticky mismatch flag, cleared only when the next session starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_q <= 1'b0;
        end else if (sess_start) begin
            error_q <= 1'b0;
        end else if (state_q == StCsum && xfer && csum_total != 8'd0) begin
            error_q <= 1'b1;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_tc_program_writer8.sv
// Directed self-checking bench for tc_program_writer8 (default MEM_BYTES=256).
// Checksum-specific steps are compiled in when TC_PROGRAM_WRITER_CHECKSUM_EN is defined.
module tb_tc_program_writer8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic       error;

    int errors = 0;
    int checks = 0;

    logic [7:0] wa[$];
    logic [7:0] wd[$];

    tc_program_writer8 #(.MEM_BYTES(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Log every write strobe mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (wr_en) begin
            wa.push_back(wr_addr);
            wd.push_back(wr_data);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] b);
        base_addr = b;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    // Present a byte and hold it until it is accepted (bounded wait).
    task automatic send(input logic [7:0] b);
        int n;
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (n == 20) check("in_ready_wait", in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_csum(input logic [7:0] b);
`ifdef TC_PROGRAM_WRITER_CHECKSUM_EN
        send(b);
`else
        in_data = b;
`endif
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 10) begin
            step();
            n++;
        end
        check({tag, "_done"}, done, 1);
        step();
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [7:0] a,
                            input logic [7:0] d);
        if (idx < wa.size()) begin
            check({tag, "_addr"}, wa[idx], a);
            check({tag, "_data"}, wd[idx], d);
        end else begin
            check({tag, "_missing"}, wa.size(), idx + 1);
        end
    endtask

    initial begin
        int bad;
        rst = 1'b1; start = 1'b0; base_addr = 8'h00; in_valid = 1'b0; in_data = 8'h00;
        step();
        step();
        check("rst_in_ready", in_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        rst = 1'b0;
        step();
        check("idle_in_ready", in_ready, 0);

        // Basic load, back-to-back bytes.
        wa.delete(); wd.delete();
        do_start(8'h10);
        check("t1_busy", busy, 1);
        check("t1_in_ready", in_ready, 1);
        send(8'h03); send(8'hAA); send(8'hBB); send(8'hCC);
        send_csum(8'hCC);  // 03+AA+BB+CC = 0x234, low byte 0x34, complement 0xCC
        wait_done("t1");
        check("t1_count", wa.size(), 3);
        check_wr("t1_w0", 0, 8'h10, 8'hAA);
        check_wr("t1_w1", 1, 8'h11, 8'hBB);
        check_wr("t1_w2", 2, 8'h12, 8'hCC);
        check("t1_error", error, 0);

        // Address wrap 0xFF -> 0x00.
        wa.delete(); wd.delete();
        do_start(8'hFE);
        send(8'h03); send(8'h01); send(8'h02); send(8'h03);
        send_csum(8'hF7);
        wait_done("t2");
        check("t2_count", wa.size(), 3);
        check_wr("t2_w0", 0, 8'hFE, 8'h01);
        check_wr("t2_w1", 1, 8'hFF, 8'h02);
        check_wr("t2_w2", 2, 8'h00, 8'h03);
        check("t2_error", error, 0);

        // Length 0 means a full 256-byte load.
        wa.delete(); wd.delete();
        do_start(8'h80);
        send(8'h00);
        for (int i = 0; i < 256; i++) send(8'(i));
        send_csum(8'h80);
        wait_done("t3");
        check("t3_count", wa.size(), 256);
        bad = 0;
        for (int i = 0; i < 256 && i < wa.size(); i++) begin
            if (wa[i] !== 8'(8'h80 + i) || wd[i] !== 8'(i)) bad++;
        end
        check("t3_contents_bad", bad, 0);
        check_wr("t3_last", 255, 8'h7F, 8'hFF);

`ifdef TC_PROGRAM_WRITER_CHECKSUM_EN
        // Bad checksum sets a sticky error; the next start clears it.
        wa.delete(); wd.delete();
        do_start(8'h00);
        send(8'h01); send(8'h55);
        send(8'h00);
        wait_done("t4");
        check("t4_error_set", error, 1);
        check("t4_count", wa.size(), 1);
        do_start(8'h00);
        check("t4_error_cleared", error, 0);
        send(8'h01); send(8'h11); send(8'hEE);
        wait_done("t4b");
        check("t4b_error", error, 0);
`endif

        // Reset after the 2nd of 4 data bytes drops the pending strobe.
        wa.delete(); wd.delete();
        do_start(8'h40);
        send(8'h04); send(8'h01); send(8'h02);
        rst = 1'b1;
        #1;
        check("t5_async_wr_en", wr_en, 0);
        check("t5_async_busy", busy, 0);
        step();
        check("t5_in_ready", in_ready, 0);
        check("t5_wr_en", wr_en, 0);
        check("t5_wr_addr", wr_addr, 0);
        check("t5_wr_data", wr_data, 0);
        check("t5_done", done, 0);
        check("t5_error", error, 0);
        rst = 1'b0;
        in_valid = 1'b1; in_data = 8'h77;
        step(); step(); step();
        in_valid = 1'b0;
        check("t5_count", wa.size(), 1);
        check_wr("t5_w0", 0, 8'h40, 8'h01);
        check("t5_idle", busy, 0);
        wa.delete(); wd.delete();
        do_start(8'h20);
        send(8'h02); send(8'h5A); send(8'hA5);
        send_csum(8'hFF);
        wait_done("t5b");
        check("t5b_count", wa.size(), 2);
        check_wr("t5b_w0", 0, 8'h20, 8'h5A);
        check_wr("t5b_w1", 1, 8'h21, 8'hA5);

        // Gapped valid with a stray start while busy.
        wa.delete(); wd.delete();
        do_start(8'h30);
        send(8'h02);
        start = 1'b1; base_addr = 8'h99;
        in_valid = 1'b1; in_data = 8'h11;
        step();
        in_valid = 1'b0; in_data = 8'hEE;
        step();
        check("t6_busy_mid", busy, 1);
        in_valid = 1'b1; in_data = 8'h22;
        step();
        in_valid = 1'b0; start = 1'b0;
        send_csum(8'hCB);
        wait_done("t6");
        check("t6_count", wa.size(), 2);
        check_wr("t6_w0", 0, 8'h30, 8'h11);
        check_wr("t6_w1", 1, 8'h31, 8'h22);
        check("t6_error", error, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
